// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asynchronous assertion of all domain resets,
// synchronised release followed by a hold time and a staggered, in-order
// release of each domain. A synchronous software request re-runs the release.
`timescale 1ns/1ps

module reset_release_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned N_OUT       = 4
) (
  input  logic                         CLK,
  input  logic                         RSTB,
  input  logic                         SW_RST,
  output logic [N_OUT-1:0]             RSTB_OUT,
  output logic [$clog2(N_OUT+1)-1:0]   REL_CNT,
  output logic                         DONE
);

  localparam int unsigned RW   = $clog2(N_OUT + 1);
  localparam int unsigned MAXC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    STEP_LOAD = CW'(STEP_CYCLES - 1);
  localparam logic [RW-1:0]    LAST_IDX  = RW'(N_OUT - 1);
  localparam logic [N_OUT-1:0] FIRST_BIT = N_OUT'(1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_flag;
  state_t                 state;
  logic [CW-1:0]          cnt;

  assign sync_flag = sync_q[SYNC_STAGES-1];

  // Deassertion synchroniser: clears asynchronously, fills with ones after RSTB rises
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Sequencing FSM; every output is a flop with the async clear on RSTB
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= ST_RESET;
      cnt      <= '0;
      RSTB_OUT <= '0;
      REL_CNT  <= '0;
      DONE     <= 1'b0;
    end else if (state == ST_RESET) begin
      // Software request has no effect until the synchronised release
      if (sync_flag) begin
        state <= ST_HOLD;
        cnt   <= HOLD_LOAD;
      end
    end else if (SW_RST) begin
      // Software request beats any release scheduled on this edge
      state    <= ST_HOLD;
      cnt      <= HOLD_LOAD;
      RSTB_OUT <= '0;
      REL_CNT  <= '0;
      DONE     <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == '0) begin
            RSTB_OUT <= FIRST_BIT;
            REL_CNT  <= RW'(1);
            cnt      <= STEP_LOAD;
            if (N_OUT == 1) begin
              state <= ST_RUN;
              DONE  <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) begin
            // Bits are released in index order, so the next one is a shift-in
            RSTB_OUT <= (RSTB_OUT << 1) | FIRST_BIT;
            REL_CNT  <= REL_CNT + RW'(1);
            if (REL_CNT == LAST_IDX) begin
              state <= ST_RUN;
              DONE  <= 1'b1;
            end else begin
              cnt <= STEP_LOAD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: stimulus pushes expected output changes (edge number and
// value), monitors pop and compare whenever the DUT outputs change.
`timescale 1ns/1ps

module tb_reset_release_sequencer;

  typedef struct {
    int         edge_n;
    logic [3:0] out;
    logic [2:0] cnt;
    logic       done;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstb_a = 1'b0;
  logic       sw_a = 1'b0;
  logic [3:0] rstb_out_a;
  logic [2:0] rel_cnt_a;
  logic       done_a;

  logic       rstb_b = 1'b0;
  logic       sw_b = 1'b0;
  logic [0:0] rstb_out_b;
  logic [0:0] rel_cnt_b;
  logic       done_b;

  int  checks = 0;
  int  failures = 0;
  int  ecnt_a = 0;
  int  ecnt_b = 0;
  bit  corner_done = 1'b0;
  ev_t q_a[$];
  ev_t q_b[$];
  logic [7:0] prev_a = '0;
  logic [7:0] cur_a;
  logic [2:0] prev_b = '0;
  logic [2:0] cur_b;
  ev_t ev_a;
  ev_t ev_b;

  always #5 clk = ~clk;

  reset_release_sequencer dut_a (
    .CLK(clk), .RSTB(rstb_a), .SW_RST(sw_a),
    .RSTB_OUT(rstb_out_a), .REL_CNT(rel_cnt_a), .DONE(done_a)
  );

  reset_release_sequencer #(
    .SYNC_STAGES(3), .HOLD_CYCLES(1), .STEP_CYCLES(1), .N_OUT(1)
  ) dut_b (
    .CLK(clk), .RSTB(rstb_b), .SW_RST(sw_b),
    .RSTB_OUT(rstb_out_b), .REL_CNT(rel_cnt_b), .DONE(done_b)
  );

  // Edge numbering: edge 1 is the first rising edge with reset released
  always @(posedge clk or negedge rstb_a) begin
    if (!rstb_a) ecnt_a <= 0;
    else         ecnt_a <= ecnt_a + 1;
  end

  always @(posedge clk or negedge rstb_b) begin
    if (!rstb_b) ecnt_b <= 0;
    else         ecnt_b <= ecnt_b + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_a(input int e, input logic [3:0] o, input logic [2:0] c, input logic d);
    ev_t ev;
    ev.edge_n = e; ev.out = o; ev.cnt = c; ev.done = d;
    q_a.push_back(ev);
  endtask

  task automatic push_b(input int e, input logic o, input logic c, input logic d);
    ev_t ev;
    ev.edge_n = e; ev.out = {3'b000, o}; ev.cnt = {2'b00, c}; ev.done = d;
    q_b.push_back(ev);
  endtask

  task automatic push_full_seq_a(input int e0);
    push_a(e0,      4'b0001, 3'd1, 1'b0);
    push_a(e0 + 4,  4'b0011, 3'd2, 1'b0);
    push_a(e0 + 8,  4'b0111, 3'd3, 1'b0);
    push_a(e0 + 12, 4'b1111, 3'd4, 1'b1);
  endtask

  // Advance to the negedge following edge n, then step clear of the edge
  task automatic wait_a(input int n);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (ecnt_a != n && g < 2000);
    if (ecnt_a != n) check("wait_a_timeout", 64'(ecnt_a), 64'(n));
    #2;
  endtask

  task automatic wait_b(input int n);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (ecnt_b != n && g < 2000);
    if (ecnt_b != n) check("wait_b_timeout", 64'(ecnt_b), 64'(n));
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    cur_a = {rstb_out_a, rel_cnt_a, done_a};
    if (cur_a !== prev_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_change", 64'(cur_a), 64'(prev_a));
      end else begin
        ev_a = q_a.pop_front();
        check("a_edge", 64'(ecnt_a), 64'(ev_a.edge_n));
        check("a_value", 64'(cur_a), 64'({ev_a.out, ev_a.cnt, ev_a.done}));
      end
      prev_a = cur_a;
    end
  end

  // Monitor for the corner-parameter instance
  always @(negedge clk) begin
    cur_b = {rstb_out_b, rel_cnt_b, done_b};
    if (cur_b !== prev_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_change", 64'(cur_b), 64'(prev_b));
      end else begin
        ev_b = q_b.pop_front();
        check("b_edge", 64'(ecnt_b), 64'(ev_b.edge_n));
        check("b_value", 64'(cur_b), 64'({ev_b.out[0], ev_b.cnt[0], ev_b.done}));
      end
      prev_b = cur_b;
    end
  end

  // Corner parameters: release at edge 5, then a 1 ns glitch in RUN
  initial begin
    cycles(3);
    check("b_reset_state", 64'({rstb_out_b, rel_cnt_b, done_b}), 64'(0));
    push_b(5, 1'b1, 1'b1, 1'b1);
    rstb_b = 1'b1;
    wait_b(8);
    @(posedge clk);
    #1;
    push_b(0, 1'b0, 1'b0, 1'b0);
    rstb_b = 1'b0;
    #0.5;
    check("b_glitch_immediate", 64'({rstb_out_b, rel_cnt_b, done_b}), 64'(0));
    #0.5;
    rstb_b = 1'b1;
    push_b(5, 1'b1, 1'b1, 1'b1);
    wait_b(8);
    corner_done = 1'b1;
  end

  // Default-parameter stimulus
  initial begin
    int g;
    cycles(3);
    check("a_reset_state", 64'({rstb_out_a, rel_cnt_a, done_a}), 64'(0));

    // Power-on release
    push_full_seq_a(19);
    rstb_a = 1'b1;
    wait_a(33);

    // Async reset mid-sequence at edge 24, then identical restart
    push_a(0, 4'b0000, 3'd0, 1'b0);
    rstb_a = 1'b0;
    cycles(2);
    push_a(19, 4'b0001, 3'd1, 1'b0);
    push_a(23, 4'b0011, 3'd2, 1'b0);
    rstb_a = 1'b1;
    wait_a(24);
    push_a(0, 4'b0000, 3'd0, 1'b0);
    rstb_a = 1'b0;
    #1;
    check("a_async_immediate", 64'({rstb_out_a, rel_cnt_a, done_a}), 64'(0));
    cycles(2);
    push_full_seq_a(19);
    rstb_a = 1'b1;
    wait_a(33);

    // Single-cycle software reset in RUN at edge 41
    wait_a(40);
    push_a(41, 4'b0000, 3'd0, 1'b0);
    push_full_seq_a(57);
    sw_a = 1'b1;
    cycles(1);
    sw_a = 1'b0;
    wait_a(72);

    // Five-cycle software reset starting at edge 80
    wait_a(79);
    push_a(80, 4'b0000, 3'd0, 1'b0);
    push_full_seq_a(100);
    sw_a = 1'b1;
    cycles(5);
    sw_a = 1'b0;
    wait_a(114);

    // Software reset sampled at edge 1 (still in RESET) is ignored
    push_a(0, 4'b0000, 3'd0, 1'b0);
    rstb_a = 1'b0;
    cycles(2);
    push_full_seq_a(19);
    sw_a = 1'b1;
    rstb_a = 1'b1;
    cycles(1);
    sw_a = 1'b0;
    wait_a(33);

    // Software reset on the edge-23 release: no bit rises, sequence restarts
    push_a(0, 4'b0000, 3'd0, 1'b0);
    rstb_a = 1'b0;
    cycles(2);
    push_a(19, 4'b0001, 3'd1, 1'b0);
    push_a(23, 4'b0000, 3'd0, 1'b0);
    push_full_seq_a(39);
    rstb_a = 1'b1;
    wait_a(22);
    sw_a = 1'b1;
    cycles(1);
    sw_a = 1'b0;
    wait_a(53);

    g = 0;
    while (!corner_done && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("b_corner_finished", 64'(corner_done), 64'(1));
    check("a_queue_empty", 64'(q_a.size()), 64'(0));
    check("b_queue_empty", 64'(q_b.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
